// File: rtl/vga_ctrl_if.sv
// VGA output and Wishbone read-master interfaces.
// video_if: CLK/HS/VS/BLANK/RGB; wshb_if: classic Wishbone, clk/rst as ports.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

interface wshb_if (input logic clk, input logic rst);
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic        err;
  logic        rty;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output dat_ms, adr, cyc, stb, we, sel, cti, bte
  );
  modport slave (
    input  clk, rst, dat_ms, adr, cyc, stb, we, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/vga_ctrl.sv
// VGA controller: Wishbone framebuffer fetch -> async FIFO -> pixel timing.
// Ports: pixel_clk/pixel_rst, video_ifm (video_if.master),
//   wshb_ifm (wshb_if.master), test_mode, underflow (sticky).
// Option: VGA_TEST_PATTERN_EN adds 8 colour bars selected by test_mode.
module vga_ctrl #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          HFP      = 40,
  parameter int          HPULSE   = 48,
  parameter int          HBP      = 40,
  parameter int          VFP      = 13,
  parameter int          VPULSE   = 3,
  parameter int          VBP      = 29,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter logic [31:0] FB_BASE  = 32'h0,
  parameter int          FIFO_DW  = 8,
  parameter int          PIX_MODE = 0
) (
  input  logic    pixel_clk,
  input  logic    pixel_rst,
  video_if.master video_ifm,
  wshb_if.master  wshb_ifm,
  input  logic    test_mode,
  output logic    underflow
);

  localparam int XLEN   = HDISP + HFP + HPULSE + HBP;
  localparam int YLEN   = VDISP + VFP + VPULSE + VBP;
  localparam int XW     = $clog2(XLEN + 1);
  localparam int YW     = $clog2(YLEN + 1);
  localparam int DEPTH  = 1 << FIFO_DW;
  localparam int NWORDS = (PIX_MODE == 0) ? HDISP * VDISP
                                          : HDISP * VDISP / 2;
  localparam int NWW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(XLEN - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(HDISP);
  localparam logic [XW-1:0] HS_ON  = XW'(HDISP + HFP);
  localparam logic [XW-1:0] HS_OFF = XW'(HDISP + HFP + HPULSE);
  localparam logic [YW-1:0] Y_LAST = YW'(YLEN - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(VDISP);
  localparam logic [YW-1:0] VS_ON  = YW'(VDISP + VFP);
  localparam logic [YW-1:0] VS_OFF = YW'(VDISP + VFP + VPULSE);

  localparam logic [FIFO_DW:0] AF_LVL = (FIFO_DW + 1)'(DEPTH - 2);
  localparam logic [NWW-1:0]   W_LAST = NWW'(NWORDS - 1);

  function automatic logic [FIFO_DW:0] g2b(input logic [FIFO_DW:0] g);
    logic [FIFO_DW:0] b;
    b[FIFO_DW] = g[FIFO_DW];
    for (int i = FIFO_DW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------- write (Wishbone) domain ----------------
  logic wclk;
  logic wrst_raw;
  logic [1:0] wrst_q;
  logic wrst;

  assign wclk     = wshb_ifm.clk;
  // A pixel-only reset also flushes the fetch side so the frame refetches.
  assign wrst_raw = wshb_ifm.rst | pixel_rst;
  assign wrst     = wrst_q[1];

  always_ff @(posedge wclk or posedge wrst_raw) begin
    if (wrst_raw) wrst_q <= 2'b11;
    else          wrst_q <= {wrst_q[0], 1'b0};
  end

  logic [31:0]      mem [DEPTH];
  logic [FIFO_DW:0] wbin, wgray, wq1, wq2;
  logic [FIFO_DW:0] rbin, rgray, rq1, rq2;
  logic [FIFO_DW:0] wbin_nx, level;
  logic [31:0]      adr;
  logic [NWW-1:0]   widx;
  logic             almost, req, accept, fill_q;

  assign wbin_nx = wbin + 1'b1;
  assign level   = wbin - g2b(wq2);
  assign almost  = level >= AF_LVL;
  assign req     = !wrst && !almost;
  assign accept  = req && wshb_ifm.ack;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin   <= '0;
      wgray  <= '0;
      wq1    <= '0;
      wq2    <= '0;
      adr    <= FB_BASE;
      widx   <= '0;
      fill_q <= 1'b0;
    end else begin
      wq1    <= rgray;
      wq2    <= wq1;
      fill_q <= almost;
      if (accept) begin
        wbin  <= wbin_nx;
        wgray <= wbin_nx ^ (wbin_nx >> 1);
        if (widx == W_LAST) begin
          widx <= '0;
          adr  <= FB_BASE;
        end else begin
          widx <= widx + 1'b1;
          adr  <= adr + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (accept) mem[wbin[FIFO_DW-1:0]] <= wshb_ifm.dat_sm;
  end

  assign wshb_ifm.cyc    = req;
  assign wshb_ifm.stb    = req;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = 4'hF;
  assign wshb_ifm.cti    = 3'd0;
  assign wshb_ifm.bte    = 2'd0;
  assign wshb_ifm.adr    = adr;
  assign wshb_ifm.dat_ms = 32'h0;

  // ---------------- pixel domain ----------------
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [1:0]    fs;
  logic          en, pop, starve, active, rempty, tm;
  logic [31:0]   rdata;
  logic [15:0]   p16;
  logic [23:0]   conv, rgb_n;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      px <= '0;
      py <= '0;
    end else if (px == X_LAST) begin
      px <= '0;
      py <= (py == Y_LAST) ? '0 : py + 1'b1;
    end else begin
      px <= px + 1'b1;
    end
  end

  assign active = (px < X_ACT) && (py < Y_ACT);
  assign rempty = (rgray == rq2);
  assign rdata  = mem[rbin[FIFO_DW-1:0]];

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  bar;
  logic [23:0] bar_rgb;
  assign tm      = test_mode;
  assign bar     = 3'((int'(px) * 8) / HDISP);
  // Bar order white..black maps to inverted index bits per channel.
  assign bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
`else
  assign tm = 1'b0;
`endif

  always_comb begin
    p16    = px[0] ? rdata[31:16] : rdata[15:0];
    conv   = '0;
    if (PIX_MODE == 0) begin
      conv = {rdata[7:0], rdata[15:8], rdata[23:16]};
      pop  = en && active && !rempty && !tm;
    end else begin
      conv = {p16[15:11], p16[15:13],
              p16[10:5],  p16[10:9],
              p16[4:0],   p16[4:2]};
      pop  = en && active && px[0] && !rempty && !tm;
    end
    starve = en && active && rempty && !tm;
    rgb_n  = (en && active && !rempty) ? conv : 24'h0;
`ifdef VGA_TEST_PATTERN_EN
    if (tm) rgb_n = active ? bar_rgb : 24'h0;
`endif
  end

  logic        hs_q, vs_q, blank_q;
  logic [23:0] rgb_q;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      rq1       <= '0;
      rq2       <= '0;
      rbin      <= '0;
      rgray     <= '0;
      fs        <= 2'b00;
      en        <= 1'b0;
      underflow <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_q   <= 1'b0;
      rgb_q     <= 24'h0;
    end else begin
      rq1 <= wgray;
      rq2 <= rq1;
      fs  <= {fs[0], fill_q};
      // Arm only in vertical blanking so display begins at pixel (0,0).
      if (fs[1] && px >= X_ACT && py >= Y_ACT) en <= 1'b1;
      if (starve) underflow <= 1'b1;
      if (pop) begin
        rbin  <= rbin + 1'b1;
        rgray <= (rbin + 1'b1) ^ ((rbin + 1'b1) >> 1);
      end
      hs_q    <= (px >= HS_ON && px < HS_OFF) ? HS_POL : ~HS_POL;
      vs_q    <= (py >= VS_ON && py < VS_OFF) ? VS_POL : ~VS_POL;
      blank_q <= active;
      rgb_q   <= rgb_n;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;

  logic unused_ok;
  assign unused_ok = ^{test_mode, wshb_ifm.err, wshb_ifm.rty, rdata[31:24]};

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl: timing, fetch order, RGB565 mode,
// underflow, mid-line reset and (optionally) the colour-bar pattern.
module tb_vga_ctrl;

  logic pclk = 1'b0;
  logic wclk = 1'b0;
  logic prst;
  logic wrst;
  logic tmode;
  logic hold0;
  logic uf0, uf1;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int k, px, py, fr;

  always #5 pclk = ~pclk;
  always #3 wclk = ~wclk;

  video_if v0 ();
  video_if v1 ();
  wshb_if  wb0 (.clk(wclk), .rst(wrst));
  wshb_if  wb1 (.clk(wclk), .rst(wrst));

  assign wb0.err = 1'b0;
  assign wb0.rty = 1'b0;
  assign wb1.err = 1'b0;
  assign wb1.rty = 1'b0;

  // Memory models: data = address (dut1 returns a fixed word at 0).
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wb0.ack    <= 1'b0;
      wb0.dat_sm <= 32'h0;
    end else begin
      wb0.ack    <= wb0.cyc && wb0.stb && !wb0.ack && !hold0;
      wb0.dat_sm <= wb0.adr;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wb1.ack    <= 1'b0;
      wb1.dat_sm <= 32'h0;
    end else begin
      wb1.ack    <= wb1.cyc && wb1.stb && !wb1.ack;
      wb1.dat_sm <= (wb1.adr == 32'h0) ? 32'h07E0_F800 : wb1.adr;
    end
  end

  vga_ctrl #(
    .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
    .VFP(2), .VPULSE(2), .VBP(2), .HS_POL(1'b0), .VS_POL(1'b0),
    .FB_BASE(32'h1000), .FIFO_DW(4), .PIX_MODE(0)
  ) dut0 (
    .pixel_clk(pclk), .pixel_rst(prst), .video_ifm(v0),
    .wshb_ifm(wb0), .test_mode(tmode), .underflow(uf0)
  );

  vga_ctrl #(
    .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
    .VFP(2), .VPULSE(2), .VBP(2), .HS_POL(1'b0), .VS_POL(1'b0),
    .FB_BASE(32'h0), .FIFO_DW(4), .PIX_MODE(1)
  ) dut1 (
    .pixel_clk(pclk), .pixel_rst(prst), .video_ifm(v1),
    .wshb_ifm(wb1), .test_mode(1'b0), .underflow(uf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s k=%0d obs=%h exp=%h", tag, k, obs, exp);
      $error("check %s k=%0d obs=%h exp=%h", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    k  = n;
    n  = n + 1;
    px = k % 14;
    py = (k / 14) % 10;
    fr = k / 140;
  endtask

  function automatic logic [23:0] rgb565(input int x, input int y);
    if (y != 0) return 24'hxxxxxx;
    case (x)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h000021;
      4: return 24'h000042;
      default: return 24'hxxxxxx;
    endcase
  endfunction

  task automatic run(input int cnt, input bit rgb_chk);
    logic        blk;
    logic [31:0] w;
    logic [23:0] e;
    for (int i = 0; i < cnt; i++) begin
      tick();
      blk = (px < 8) && (py < 4);
      chk("hs", v0.HS, !(px >= 10 && px < 12));
      chk("vs", v0.VS, !(py >= 6 && py < 8));
      chk("blank", v0.BLANK, blk);
      chk("blank1", v1.BLANK, blk);
      chk("uf1", uf1, 1'b0);
      if (!blk || fr == 0) chk("rgb1_zero", v1.RGB, 24'h0);
      else if (py == 0 && px inside {0, 1, 2, 4})
        chk("rgb1_565", v1.RGB, rgb565(px, py));
      if (rgb_chk) begin
        w = 32'h1000 + 32'(4 * (py * 8 + px));
        e = (fr == 0 || !blk) ? 24'h0 : {w[7:0], w[15:8], w[23:16]};
        chk("rgb0", v0.RGB, e);
        chk("uf0", uf0, 1'b0);
      end else if (!blk) begin
        chk("rgb0_blank", v0.RGB, 24'h0);
      end
    end
  endtask

  initial begin
    prst  = 1'b1;
    wrst  = 1'b1;
    tmode = 1'b0;
    hold0 = 1'b0;
    k     = -1;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_hs", v0.HS, 1'b1);
    chk("rst_vs", v0.VS, 1'b1);
    chk("rst_blank", v0.BLANK, 1'b0);
    chk("rst_rgb", v0.RGB, 24'h0);
    chk("rst_uf", uf0, 1'b0);
    chk("rst_cyc", wb0.cyc, 1'b0);
    chk("rst_clk", v0.CLK, pclk);

    @(negedge pclk);
    prst = 1'b0;
    wrst = 1'b0;
    n    = 0;
    run(420, 1'b1);

    // Starve dut0: withhold ack for ~200 pixel cycles.
    hold0 = 1'b1;
    run(42, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("starve_rgb", v0.RGB, 24'h0);
    end
    run(150, 1'b0);
    chk("uf_set", uf0, 1'b1);
    hold0 = 1'b0;
    run(80, 1'b0);
    chk("uf_sticky", uf0, 1'b1);

    // Mid-line pixel reset at px=4 of line 0.
    run(5, 1'b0);
    chk("pre_blank", v0.BLANK, 1'b1);
    chk("pre_rgb1", v1.RGB, 24'h000042);
    #3;
    prst = 1'b1;
    #1;
    chk("mid_hs", v0.HS, 1'b1);
    chk("mid_vs", v0.VS, 1'b1);
    chk("mid_blank", v0.BLANK, 1'b0);
    chk("mid_rgb", v0.RGB, 24'h0);
    chk("mid_rgb1", v1.RGB, 24'h0);
    chk("mid_uf", uf0, 1'b0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    prst = 1'b0;
    n    = 0;
    run(280, 1'b1);

`ifdef VGA_TEST_PATTERN_EN
    tmode = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (px == 0) chk("bar_white", v0.RGB, 24'hFFFFFF);
      if (px == 5) chk("bar_red", v0.RGB, 24'hFF0000);
      chk("bar_uf", uf0, 1'b0);
    end
    tmode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
